// File: rtl/acc_pkg.sv
// Shared accelerator types: register-file data/address widths and the
// writeback buffer entry layout.
package acc_pkg;

    localparam int ACC_DATA_W = 32;
    localparam int ACC_ADDR_W = 5;
    localparam int WB_DEPTH   = 4;

    typedef logic [ACC_DATA_W-1:0] data_t;
    typedef logic [ACC_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t tag;
        data_t     data;
    } wb_entry_t;

endpackage

// File: rtl/acc_wb_fwd_lookup.sv
// Combinational forwarding search over the writeback buffer: finds the
// youngest valid entry whose destination tag matches the lookup address.
module acc_wb_fwd_lookup
    import acc_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t [DEPTH-1:0] entries,
    input  logic      [DEPTH-1:0] valid,
    input  logic      [PTR_W-1:0] rd_ptr,
    input  reg_addr_t             addr,
    output logic                  hit,
    output data_t                 data
);

    logic [PTR_W-1:0] idx;

    // Walk from the head (oldest) towards the tail so later matches override
    // earlier ones; the last match seen is the youngest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (valid[idx] && (entries[idx].tag == addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/acc_wb_buffer.sv
// In-order writeback FIFO between the FPU result port and the accelerator
// register-file write port, with by-address forwarding of pending results.
module acc_wb_buffer
    import acc_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = ACC_DATA_W,
    parameter int ADDR_W = ACC_ADDR_W
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       fpu_out_valid_i,
    output logic                       fpu_out_ready_o,
    input  logic [DATA_W-1:0]          fpu_result_i,
    input  logic [ADDR_W-1:0]          fpu_tag_i,
    input  logic                       flush_i,
    input  logic                       rf_busy_i,
    output logic                       rf_wren_o,
    output logic [ADDR_W-1:0]          rf_waddr_o,
    output logic [DATA_W-1:0]          rf_wdata_o,
    input  logic [ADDR_W-1:0]          fwd_raddr_i,
    output logic                       fwd_valid_o,
    output logic [DATA_W-1:0]          fwd_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t [DEPTH-1:0] entries;
    logic      [DEPTH-1:0] valid;
    logic      [PTR_W-1:0] wr_ptr;
    logic      [PTR_W-1:0] rd_ptr;
    logic      [CNT_W-1:0] count;
    logic                  push;
    logic                  pop;

    // Ready and write enable depend only on registered occupancy, so a full
    // buffer never accepts in the same cycle it frees a slot.
    assign empty_o         = (count == '0);
    assign count_o         = count;
    assign fpu_out_ready_o = (count != FULL_CNT) && !flush_i;
    assign rf_wren_o       = !empty_o && !rf_busy_i && !flush_i;
    assign rf_waddr_o      = entries[rd_ptr].tag;
    assign rf_wdata_o      = entries[rd_ptr].data;
    assign push            = fpu_out_valid_i && fpu_out_ready_o;
    assign pop             = rf_wren_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entries <= '0;
            valid   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else if (flush_i) begin
            valid  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (push) begin
                entries[wr_ptr] <= '{tag: fpu_tag_i, data: fpu_result_i};
                valid[wr_ptr]   <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    acc_wb_fwd_lookup #(
        .DEPTH(DEPTH)
    ) u_fwd_lookup (
        .entries(entries),
        .valid  (valid),
        .rd_ptr (rd_ptr),
        .addr   (fwd_raddr_i),
        .hit    (fwd_valid_o),
        .data   (fwd_data_o)
    );

endmodule

// File: tb/tb_acc_wb_buffer.sv
// Self-checking bench for acc_wb_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based model of the buffer.
module tb_acc_wb_buffer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        fpu_out_valid_i = 1'b0;
    logic        fpu_out_ready_o;
    logic [31:0] fpu_result_i = '0;
    logic [4:0]  fpu_tag_i = '0;
    logic        flush_i = 1'b0;
    logic        rf_busy_i = 1'b0;
    logic        rf_wren_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [4:0]  fwd_raddr_i = '0;
    logic        fwd_valid_o;
    logic [31:0] fwd_data_o;
    logic [2:0]  count_o;
    logic        empty_o;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] data;
    } model_t;

    model_t q[$];
    int     checks_total  = 0;
    int     checks_passed = 0;

    acc_wb_buffer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .fpu_out_valid_i(fpu_out_valid_i),
        .fpu_out_ready_o(fpu_out_ready_o),
        .fpu_result_i   (fpu_result_i),
        .fpu_tag_i      (fpu_tag_i),
        .flush_i        (flush_i),
        .rf_busy_i      (rf_busy_i),
        .rf_wren_o      (rf_wren_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .fwd_raddr_i    (fwd_raddr_i),
        .fwd_valid_o    (fwd_valid_o),
        .fwd_data_o     (fwd_data_o),
        .count_o        (count_o),
        .empty_o        (empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    endtask

    // Expected outputs come straight from the queue: size gives occupancy,
    // front is the next write, last tag match is the youngest pending result.
    task automatic checkModel();
        logic        exp_ready;
        logic        exp_wren;
        logic        exp_hit;
        logic [31:0] exp_fwd;
        exp_ready = (q.size() < 4) && !flush_i;
        exp_wren  = (q.size() > 0) && !rf_busy_i && !flush_i;
        exp_hit   = 1'b0;
        exp_fwd   = '0;
        foreach (q[k]) begin
            if (q[k].tag == fwd_raddr_i) begin
                exp_hit = 1'b1;
                exp_fwd = q[k].data;
            end
        end
        checkOutput("ready", 32'(fpu_out_ready_o), 32'(exp_ready));
        checkOutput("wren", 32'(rf_wren_o), 32'(exp_wren));
        if (exp_wren) begin
            checkOutput("waddr", 32'(rf_waddr_o), 32'(q[0].tag));
            checkOutput("wdata", rf_wdata_o, q[0].data);
        end
        checkOutput("fwd_valid", 32'(fwd_valid_o), 32'(exp_hit));
        checkOutput("fwd_data", fwd_data_o, exp_fwd);
        checkOutput("count", 32'(count_o), 32'(q.size()));
        checkOutput("empty", 32'(empty_o), 32'(q.size() == 0));
    endtask

    // One clock cycle: drive just after the rising edge, check at the falling
    // edge, then advance the model at the next rising edge.
    task automatic applyStimulus(input logic v, input logic [4:0] tag, input logic [31:0] d,
                                 input logic busy, input logic fl, input logic [4:0] raddr);
        logic   do_push;
        logic   do_pop;
        model_t e;
        fpu_out_valid_i = v;
        fpu_tag_i       = tag;
        fpu_result_i    = d;
        rf_busy_i       = busy;
        flush_i         = fl;
        fwd_raddr_i     = raddr;
        @(negedge clk_i);
        checkModel();
        do_push = v && (q.size() < 4) && !fl;
        do_pop  = (q.size() > 0) && !busy && !fl;
        @(posedge clk_i);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.tag  = tag;
                e.data = d;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) begin
            if (q.size() != 0) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        end
        checkOutput("drained", 32'(count_o), 32'd0);
    endtask

    initial begin
        #12;
        checkOutput("rst_ready", 32'(fpu_out_ready_o), 32'd1);
        checkOutput("rst_wren", 32'(rf_wren_o), 32'd0);
        checkOutput("rst_fwd", 32'(fwd_valid_o), 32'd0);
        checkOutput("rst_empty", 32'(empty_o), 32'd1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        $display("[TB] single push and write-back");
        applyStimulus(1'b1, 5'd3, 32'h3F800000, 1'b0, 1'b0, 5'd3);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd3);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd3);

        $display("[TB] fill while busy, then release");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0, 5'(12));
        end
        checkOutput("full_count", 32'(count_o), 32'd4);
        checkOutput("full_ready", 32'(fpu_out_ready_o), 32'd0);
        drain();

        $display("[TB] forwarding of duplicate tags");
        applyStimulus(1'b1, 5'd7, 32'hAAAA_0001, 1'b1, 1'b0, 5'd7);
        applyStimulus(1'b1, 5'd7, 32'hBBBB_0002, 1'b1, 1'b0, 5'd7);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd7);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd8);
        drain();

        $display("[TB] full buffer with continuous traffic");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'(i), $urandom, 1'b1, 1'b0, 5'd0);
        end
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 5'($urandom_range(0, 31)), $urandom, 1'b0, 1'b0, 5'($urandom_range(0, 3)));
        end
        drain();

        $display("[TB] flush with a result offered");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'(20 + i), $urandom, 1'b1, 1'b0, 5'd21);
        end
        applyStimulus(1'b1, 5'd21, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd21);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd21);

        $display("[TB] asynchronous reset mid-drain");
        applyStimulus(1'b1, 5'd1, 32'h1111_1111, 1'b1, 1'b0, 5'd0);
        applyStimulus(1'b1, 5'd2, 32'h2222_2222, 1'b1, 1'b0, 5'd0);
        fpu_out_valid_i = 1'b0;
        rf_busy_i       = 1'b0;
        #2;
        checkOutput("pre_rst_wren", 32'(rf_wren_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        q.delete();
        checkOutput("async_rst_wren", 32'(rf_wren_o), 32'd0);
        checkOutput("async_rst_count", 32'(count_o), 32'd0);
        checkOutput("async_rst_ready", 32'(fpu_out_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        checkOutput("in_rst_count", 32'(count_o), 32'd0);
        rst_ni = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 24) == 0),
                          5'($urandom_range(0, 7)));
        end
        drain();

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
